// File: rtl/qa_drv_hc_pkg.sv
// Shared definitions for the QA host-channel driver issue gate.
// Holds the stall-counter default width and the budget width helper.
package qa_drv_hc_pkg;

  localparam int STALL_CNT_W_DEFAULT = 16;

  // Width of a budget register able to hold 0..slack, never narrower than one bit.
  function automatic int calc_budget_w(input int slack);
    int w;
    w = $clog2(slack + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/qa_drv_hc_can_issue_chan.sv
// Single-channel issue gate: registered almostfull, post-almostfull slack budget,
// sticky overflow flag and saturating stall counter.
module qa_drv_hc_can_issue_chan
  import qa_drv_hc_pkg::*;
#(
  parameter int SLACK       = 4,
  parameter int STALL_CNT_W = STALL_CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   almostfull,
  input  logic                   issue,
  input  logic                   stat_clear,
  output logic                   can_issue,
  output logic                   overflow_err,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int                   BW        = calc_budget_w(SLACK);
  localparam logic [BW-1:0]        SLACK_LD  = BW'(SLACK);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  logic                   r_af;
  logic [BW-1:0]          r_budget;
  logic                   r_err;
  logic [STALL_CNT_W-1:0] r_stall;

  logic w_budget_nz;
  logic w_can_issue;

  // Permission is decoded from registers only, so issue/almostfull never reach it combinationally.
  assign w_budget_nz = (r_budget != {BW{1'b0}});
  assign w_can_issue = ~r_af | w_budget_nz;

  // Almostfull register and slack budget; budget is refilled whenever the registered flag is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_af     <= 1'b1;
      r_budget <= {BW{1'b0}};
    end else begin
      r_af <= almostfull;
      if (!r_af) begin
        r_budget <= SLACK_LD;
      end else if (issue && w_budget_nz) begin
        r_budget <= r_budget - BW'(1'b1);
      end else begin
        r_budget <= r_budget;
      end
    end
  end

  // Sticky overflow: an issue taken while permission was withheld.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (issue && !w_can_issue) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  // Saturating stall counter; stat_clear wins over a same-cycle stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= {STALL_CNT_W{1'b0}};
    end else if (stat_clear) begin
      r_stall <= {STALL_CNT_W{1'b0}};
    end else if (!w_can_issue && (r_stall != STALL_MAX)) begin
      r_stall <= r_stall + STALL_CNT_W'(1'b1);
    end else begin
      r_stall <= r_stall;
    end
  end

  assign can_issue    = w_can_issue;
  assign overflow_err = r_err;
  assign stall_count  = r_stall;

endmodule

// File: rtl/qa_drv_hc_credit_gate.sv
// Multi-channel issue gate between the host-channel arbiters and the QA TX FIFOs.
// Channels are independent replicas of the single-channel gate.
module qa_drv_hc_credit_gate
  import qa_drv_hc_pkg::*;
#(
  parameter int N_CHANNELS  = 2,
  parameter int SLACK       = 4,
  parameter int STALL_CNT_W = STALL_CNT_W_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CHANNELS-1:0]             almostfull,
  input  logic [N_CHANNELS-1:0]             issue,
  input  logic                              stat_clear,
  output logic [N_CHANNELS-1:0]             can_issue,
  output logic [N_CHANNELS-1:0]             overflow_err,
  output logic [N_CHANNELS*STALL_CNT_W-1:0] stall_count
);

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    qa_drv_hc_can_issue_chan #(
      .SLACK       (SLACK),
      .STALL_CNT_W (STALL_CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .almostfull   (almostfull[g]),
      .issue        (issue[g]),
      .stat_clear   (stat_clear),
      .can_issue    (can_issue[g]),
      .overflow_err (overflow_err[g]),
      .stall_count  (stall_count[g*STALL_CNT_W +: STALL_CNT_W])
    );
  end

endmodule

// File: tb/tb_qa_drv_hc_credit_gate.sv
// Directed plus randomized checks of the issue gate with two configurations:
// SLACK=4 / 16-bit counters, and SLACK=0 / 4-bit counters (legacy gate).
module tb_qa_drv_hc_credit_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] af_a, iss_a, af_b, iss_b;
  logic       clr_a, clr_b;
  logic [1:0] can_a, err_a, can_b, err_b;
  logic [31:0] stall_a;
  logic [7:0]  stall_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  qa_drv_hc_credit_gate #(.N_CHANNELS(2), .SLACK(4), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .almostfull(af_a), .issue(iss_a), .stat_clear(clr_a),
    .can_issue(can_a), .overflow_err(err_a), .stall_count(stall_a)
  );

  qa_drv_hc_credit_gate #(.N_CHANNELS(2), .SLACK(0), .STALL_CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .almostfull(af_b), .issue(iss_b), .stat_clear(clr_b),
    .can_issue(can_b), .overflow_err(err_b), .stall_count(stall_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the can_issue expected after the coming edge, then compare once it is produced.
  task automatic step_a(input string tag, input logic [1:0] exp_can);
    logic [1:0] e;
    exp_q.push_back(exp_can);
    tick();
    e = exp_q.pop_front();
    chk(tag, {30'd0, can_a}, {30'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    logic [1:0] e;
    reset = 1'b1;
    af_a = 2'b00; iss_a = 2'b00; clr_a = 1'b0;
    af_b = 2'b00; iss_b = 2'b00; clr_b = 1'b0;
    repeat (3) tick();
    chk("rst_can_a",   {30'd0, can_a}, 32'd0);
    chk("rst_err_a",   {30'd0, err_a}, 32'd0);
    chk("rst_stall_a", stall_a,        32'd0);
    chk("rst_can_b",   {30'd0, can_b}, 32'd0);
    chk("rst_stall_b", {24'd0, stall_b}, 32'd0);

    reset = 1'b0;
    chk("first_cycle_can_a", {30'd0, can_a}, 32'd0);
    tick();
    chk("cycle2_can_a",    {30'd0, can_a}, 32'd3);
    chk("cycle2_stall_a0", {16'd0, stall_a[15:0]}, 32'd1);
    chk("cycle2_stall_a1", {16'd0, stall_a[31:16]}, 32'd1);
    chk("cycle2_err_a",    {30'd0, err_a}, 32'd0);
    chk("cycle2_can_b",    {30'd0, can_b}, 32'd3);
    chk("cycle2_stall_b0", {28'd0, stall_b[3:0]}, 32'd1);
    tick();

    // Slack window without overflow
    af_a = 2'b01;
    step_a("v1_arm", 2'b11);
    iss_a = 2'b01;
    for (int k = 1; k <= 4; k++) step_a("v1_slack", (k < 4) ? 2'b11 : 2'b10);
    iss_a = 2'b00;
    step_a("v1_hold", 2'b10);
    chk("v1_no_err", {30'd0, err_a}, 32'd0);
    af_a = 2'b00;
    step_a("v1_release", 2'b11);
    step_a("v1_rearm", 2'b11);

    // Slack window followed by an illegal issue
    af_a = 2'b01;
    step_a("v2_arm", 2'b11);
    iss_a = 2'b01;
    for (int k = 1; k <= 4; k++) step_a("v2_slack", (k < 4) ? 2'b11 : 2'b10);
    step_a("v2_no_wrap", 2'b10);
    chk("v2_err_set", {30'd0, err_a}, 32'd1);
    iss_a = 2'b00;
    af_a  = 2'b00;
    step_a("v2_release", 2'b11);
    step_a("v2_rearm", 2'b11);
    chk("v2_err_sticky", {30'd0, err_a}, 32'd1);

    // High 3 cycles with 2 issues, low 1 cycle, high again: full reload expected
    af_a = 2'b01;
    step_a("tg_arm", 2'b11);
    iss_a = 2'b01;
    step_a("tg_iss1", 2'b11);
    step_a("tg_iss2", 2'b11);
    af_a  = 2'b00;
    iss_a = 2'b00;
    step_a("tg_low", 2'b11);
    af_a = 2'b01;
    step_a("tg_rearm", 2'b11);
    iss_a = 2'b01;
    for (int k = 1; k <= 4; k++) step_a("tg_reload", (k < 4) ? 2'b11 : 2'b10);
    iss_a = 2'b00;
    af_a  = 2'b00;
    chk("tg_ch1_err",   {31'd0, err_a[1]}, 32'd0);
    chk("tg_ch1_stall", {16'd0, stall_a[31:16]}, 32'd1);

    // Stall saturation and clear priority on the 4-bit, SLACK=0 instance
    af_b = 2'b01;
    repeat (20) tick();
    chk("sat_stall_b0", {28'd0, stall_b[3:0]}, 32'd15);
    chk("sat_can_b0",   {31'd0, can_b[0]}, 32'd0);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    chk("clr_stall_b0", {28'd0, stall_b[3:0]}, 32'd0);
    chk("clr_stall_b1", {28'd0, stall_b[7:4]}, 32'd0);
    tick();
    chk("clr_next_b0",  {28'd0, stall_b[3:0]}, 32'd1);
    chk("clr_next_b1",  {28'd0, stall_b[7:4]}, 32'd0);

    // Legacy equivalence: can_issue is almostfull inverted and delayed one cycle
    for (int i = 0; i < 1000; i++) begin
      r     = 2'($urandom_range(0, 3));
      af_b  = r;
      iss_b = 2'($urandom_range(0, 3));
      exp_q.push_back(~r);
      tick();
      e = exp_q.pop_front();
      chk("legacy_can_b", {30'd0, can_b}, {30'd0, e});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
